lane_pipe_reg: RTL

- Parametrised, elastic multi-lane pipeline register for the PHY TX datapath.
- Carries LANES byte-lanes (WIDTH bits each) through DEPTH register stages, with one shared valid per beat and ready/valid backpressure.
- Each stage is bubble-collapsing: an empty stage accepts new data even while the output is stalled.
- Adds flush and an occupancy count; the fixed 2-lane, 8-bit, single-stage, always-enabled flop is the degenerate case LANES=2, WIDTH=8, DEPTH=1 with out_ready tied 1.

---
 rtl/lane_pipe_reg_pkg.sv | 13 +
 rtl/lane_pipe_defs.vh | 14 +
 rtl/lane_pipe_stage.sv | 49 ++++
 rtl/lane_pipe_reg.sv | 88 ++++++++
 4 files changed

// File: rtl/lane_pipe_reg_pkg.sv
// lane_pipe_reg_pkg
// Shared constants for the PHY TX lane pipeline register.
//   LP_LANES / LP_WIDTH / LP_DEPTH : default lane count, lane width and
//                                    stage count for the PHY TX build.
`include "lane_pipe_defs.vh"

package lane_pipe_reg_pkg;

    localparam int LP_LANES = `LANE_PIPE_LANES;
    localparam int LP_WIDTH = `LANE_PIPE_WIDTH;
    localparam int LP_DEPTH = `LANE_PIPE_DEPTH;

endpackage

// File: rtl/lane_pipe_defs.vh
// lane_pipe_defs.vh
// Default geometry of the PHY TX lane pipeline and the lane-slice helper
// used to address lane k inside a packed LANES*WIDTH data word.
`ifndef LANE_PIPE_DEFS_VH
`define LANE_PIPE_DEFS_VH

`define LANE_PIPE_LANES 2
`define LANE_PIPE_WIDTH 8
`define LANE_PIPE_DEPTH 2

// Usage: word[`LANE_PIPE_SLICE(k, WIDTH)] selects lane k (lane 0 in the LSBs).
`define LANE_PIPE_SLICE(k, w) ((k)*(w)) +: (w)

`endif

// File: rtl/lane_pipe_stage.sv
// lane_pipe_stage
// One elastic register stage: a valid bit plus a DW-bit data word.
// Ports:
//   clk      : clock, posedge
//   reset    : synchronous, active-low; clears valid and data
//   flush    : synchronous clear of the valid bit (data holds)
//   adv      : stage may take the incoming beat this cycle
//   vld_in   : incoming valid (from the previous stage or the input port)
//   dat_in   : incoming data
//   vld_out  : registered valid
//   dat_out  : registered data
module lane_pipe_stage
    import lane_pipe_reg_pkg::*;
#(
    parameter int DW = LP_LANES * LP_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          adv,
    input  logic          vld_in,
    input  logic [DW-1:0] dat_in,
    output logic          vld_out,
    output logic [DW-1:0] dat_out
);

    logic          vld_q;
    logic [DW-1:0] dat_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (adv) begin
            vld_q <= vld_in;
            // Data only moves with a real beat so outputs stay quiet while
            // the valid is low.
            if (vld_in) begin
                dat_q <= dat_in;
            end
        end
    end

    assign vld_out = vld_q;
    assign dat_out = dat_q;

endmodule

// File: rtl/lane_pipe_reg.sv
// lane_pipe_reg
// Elastic, bubble-collapsing multi-lane pipeline register for the PHY TX
// datapath. LANES lanes of WIDTH bits travel together through DEPTH stages
// under one shared valid with ready/valid backpressure.
// Ports:
//   clk       : clock, posedge
//   reset     : synchronous, active-low
//   flush     : synchronous clear of every stage valid
//   in_valid  : input beat valid
//   in_data   : LANES*WIDTH input word, lane k at [k*WIDTH +: WIDTH]
//   in_ready  : pipeline accepts a beat this cycle
//   out_valid : output beat valid (last stage)
//   out_data  : LANES*WIDTH output word, same packing
//   out_ready : downstream accepts the output beat
//   occupancy : number of valid stages, 0..DEPTH
module lane_pipe_reg
    import lane_pipe_reg_pkg::*;
#(
    parameter int LANES = LP_LANES,
    parameter int WIDTH = LP_WIDTH,
    parameter int DEPTH = LP_DEPTH,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    input  logic                   out_ready,
    output logic [CNTW-1:0]        occupancy
);

    localparam int DW = LANES * WIDTH;

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic [DW-1:0]    dat [DEPTH];
    logic [CNTW-1:0]  occ_cnt;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic          vld_in;
        logic [DW-1:0] dat_in;

        if (g == 0) begin : g_head
            assign vld_in = in_valid && !flush;
            assign dat_in = in_data;
        end else begin : g_body
            assign vld_in = vld[g-1];
            assign dat_in = dat[g-1];
        end

        // Unrolled form of adv[g] = !vld[g] || adv[g+1]: a stage can move
        // when downstream takes the output or any stage from here to the
        // output is empty. Written flat to avoid a combinational chain on
        // a single vector.
        assign adv[g] = out_ready || !(&vld[DEPTH-1:g]);

        lane_pipe_stage #(
            .DW(DW)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .adv     (adv[g]),
            .vld_in  (vld_in),
            .dat_in  (dat_in),
            .vld_out (vld[g]),
            .dat_out (dat[g])
        );
    end

    // Occupancy is a plain popcount of the registered valids.
    always_comb begin
        occ_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_cnt = occ_cnt + CNTW'(vld[i]);
        end
    end

    assign in_ready  = adv[0] && !flush;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
    assign occupancy = occ_cnt;

endmodule
